memory_arbiter: RTL and testbench

Shares the single memory-access port of the frame-buffer memory manager between two requesters (client 0: host bus interface, client 1: blitter/fill engine). It accepts one read or write transaction per client via a request/done handshake, grants the port round-robin, holds the manager's request line until the matching completion pulse, and returns read data. A watchdog aborts transactions whose completion never arrives.

---
 rtl/memory_arbiter_if.sv | 48 ++++
 rtl/memory_arbiter.sv | 133 +++++++++++++
 tb/tb_memory_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// Client and memory-manager signal bundle for memory_arbiter.
// slave is the arbiter's view; master is the view of whatever drives the clients and manager.
interface memory_arbiter_if;
    logic       c0Request;
    logic       c0Write;
    logic [8:0] c0XCoord;
    logic [7:0] c0YCoord;
    logic [7:0] c0WriteData;
    logic       c0Done;
    logic       c0Error;
    logic [7:0] c0ReadData;
    logic       c1Request;
    logic       c1Write;
    logic [8:0] c1XCoord;
    logic [7:0] c1YCoord;
    logic [7:0] c1WriteData;
    logic       c1Done;
    logic       c1Error;
    logic [7:0] c1ReadData;
    logic [8:0] memoryXCoord;
    logic [7:0] memoryYCoord;
    logic       memoryReadRequest;
    logic       memoryWriteRequest;
    logic [7:0] memoryWriteData;
    logic [7:0] memoryReadData;
    logic       memoryReadComplete;
    logic       memoryWriteComplete;
    logic       busy;
    logic       grantOwner;

    modport slave (
        input  c0Request, c0Write, c0XCoord, c0YCoord, c0WriteData,
        input  c1Request, c1Write, c1XCoord, c1YCoord, c1WriteData,
        input  memoryReadData, memoryReadComplete, memoryWriteComplete,
        output c0Done, c0Error, c0ReadData, c1Done, c1Error, c1ReadData,
        output memoryXCoord, memoryYCoord, memoryReadRequest, memoryWriteRequest,
        output memoryWriteData, busy, grantOwner
    );

    modport master (
        output c0Request, c0Write, c0XCoord, c0YCoord, c0WriteData,
        output c1Request, c1Write, c1XCoord, c1YCoord, c1WriteData,
        output memoryReadData, memoryReadComplete, memoryWriteComplete,
        input  c0Done, c0Error, c0ReadData, c1Done, c1Error, c1ReadData,
        input  memoryXCoord, memoryYCoord, memoryReadRequest, memoryWriteRequest,
        input  memoryWriteData, busy, grantOwner
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing the frame-buffer manager port between two clients,
// with a watchdog that aborts transactions whose completion pulse never arrives.
module memory_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input logic clock,
    input logic reset,
    memory_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic       lastGrant;
    logic       isWrite;
    logic [7:0] timeoutCount;
    logic       anyRequest;
    logic       winner;
    logic       matchComplete;
    logic       timeoutHit;

    // Winner selection and decode of the completion pulse that matches the current operation
    always_comb begin
        anyRequest    = bus.c0Request | bus.c1Request;
        winner        = 1'b0;
        matchComplete = 1'b0;
        timeoutHit    = (timeoutCount == 8'(TIMEOUT_CYCLES - 1));
        if (bus.c0Request && bus.c1Request) begin
            winner = ~lastGrant;
        end else if (bus.c1Request) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
        if (isWrite) begin
            matchComplete = bus.memoryWriteComplete;
        end else begin
            matchComplete = bus.memoryReadComplete;
        end
    end

    // Arbitration FSM; every output is a register so the manager and clients see glitch-free lines
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                  <= IDLE;
            lastGrant              <= 1'b1;
            isWrite                <= 1'b0;
            timeoutCount           <= 8'd0;
            bus.grantOwner         <= 1'b0;
            bus.busy               <= 1'b0;
            bus.memoryReadRequest  <= 1'b0;
            bus.memoryWriteRequest <= 1'b0;
            bus.memoryXCoord       <= 9'd0;
            bus.memoryYCoord       <= 8'd0;
            bus.memoryWriteData    <= 8'd0;
            bus.c0Done             <= 1'b0;
            bus.c1Done             <= 1'b0;
            bus.c0Error            <= 1'b0;
            bus.c1Error            <= 1'b0;
            bus.c0ReadData         <= 8'd0;
            bus.c1ReadData         <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyRequest) begin
                        lastGrant      <= winner;
                        bus.grantOwner <= winner;
                        bus.busy       <= 1'b1;
                        timeoutCount   <= 8'd0;
                        state          <= BUSY;
                        if (winner) begin
                            isWrite                <= bus.c1Write;
                            bus.memoryWriteRequest <= bus.c1Write;
                            bus.memoryReadRequest  <= ~bus.c1Write;
                            bus.memoryXCoord       <= bus.c1XCoord;
                            bus.memoryYCoord       <= bus.c1YCoord;
                            bus.memoryWriteData    <= bus.c1WriteData;
                        end else begin
                            isWrite                <= bus.c0Write;
                            bus.memoryWriteRequest <= bus.c0Write;
                            bus.memoryReadRequest  <= ~bus.c0Write;
                            bus.memoryXCoord       <= bus.c0XCoord;
                            bus.memoryYCoord       <= bus.c0YCoord;
                            bus.memoryWriteData    <= bus.c0WriteData;
                        end
                    end
                end
                BUSY: begin
                    // A real completion wins over a watchdog expiry landing on the same edge
                    if (matchComplete || timeoutHit) begin
                        bus.memoryReadRequest  <= 1'b0;
                        bus.memoryWriteRequest <= 1'b0;
                        state                  <= DONE;
                        if (bus.grantOwner) begin
                            bus.c1Done  <= 1'b1;
                            bus.c1Error <= ~matchComplete;
                            if (!isWrite) begin
                                bus.c1ReadData <= matchComplete ? bus.memoryReadData : 8'd0;
                            end
                        end else begin
                            bus.c0Done  <= 1'b1;
                            bus.c0Error <= ~matchComplete;
                            if (!isWrite) begin
                                bus.c0ReadData <= matchComplete ? bus.memoryReadData : 8'd0;
                            end
                        end
                    end else begin
                        timeoutCount <= timeoutCount + 8'd1;
                    end
                end
                DONE: begin
                    bus.c0Done  <= 1'b0;
                    bus.c1Done  <= 1'b0;
                    bus.c0Error <= 1'b0;
                    bus.c1Error <= 1'b0;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    bus.memoryReadRequest  <= 1'b0;
                    bus.memoryWriteRequest <= 1'b0;
                    bus.c0Done             <= 1'b0;
                    bus.c1Done             <= 1'b0;
                    bus.busy               <= 1'b0;
                    state                  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: expected completions are queued when a grant is
// observed and popped when the done pulse appears.
module tb_memory_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        logic       client;
        logic       isError;
        logic       checkRead;
        logic [7:0] readData;
    } sb_entry_t;

    sb_entry_t sb[$];

    memory_arbiter_if bus ();

    memory_arbiter #(.TIMEOUT_CYCLES(15)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input logic client, input logic isError, input logic checkRead,
                           input logic [7:0] readData);
        sb_entry_t e;
        e.client = client;
        e.isError = isError;
        e.checkRead = checkRead;
        e.readData = readData;
        sb.push_back(e);
    endtask

    // Called right after the edge that should produce a done pulse
    task automatic popCheck(input string tag);
        sb_entry_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: scoreboard empty, observed done with no expected entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_done"}, e.client ? bus.c1Done : bus.c0Done, 1);
            check({tag, "_otherDone"}, e.client ? bus.c0Done : bus.c1Done, 0);
            check({tag, "_error"}, e.client ? bus.c1Error : bus.c0Error, e.isError);
            check({tag, "_reqLow"}, {bus.memoryReadRequest, bus.memoryWriteRequest}, 0);
            if (e.checkRead) begin
                check({tag, "_readData"}, e.client ? bus.c1ReadData : bus.c0ReadData, e.readData);
            end
        end
    endtask

    // Pulse the matching completion for one cycle, then check the done cycle and its fall
    task automatic finishTxn(input string tag, input logic isWrite, input logic [7:0] rdata);
        bus.memoryReadData = rdata;
        if (isWrite) bus.memoryWriteComplete = 1'b1;
        else bus.memoryReadComplete = 1'b1;
        tick();
        bus.memoryWriteComplete = 1'b0;
        bus.memoryReadComplete = 1'b0;
        popCheck(tag);
        check({tag, "_busyInDone"}, bus.busy, 1);
        tick();
        check({tag, "_doneFall"}, {bus.c0Done, bus.c1Done}, 0);
        check({tag, "_busyFall"}, bus.busy, 0);
    endtask

    initial begin
        bus.c0Request = 1'b0; bus.c0Write = 1'b0; bus.c0XCoord = 9'd0;
        bus.c0YCoord = 8'd0; bus.c0WriteData = 8'd0;
        bus.c1Request = 1'b0; bus.c1Write = 1'b0; bus.c1XCoord = 9'd0;
        bus.c1YCoord = 8'd0; bus.c1WriteData = 8'd0;
        bus.memoryReadData = 8'd0; bus.memoryReadComplete = 1'b0;
        bus.memoryWriteComplete = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_req", {bus.memoryReadRequest, bus.memoryWriteRequest}, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_grant", bus.grantOwner, 0);
        check("rst_done", {bus.c0Done, bus.c1Done, bus.c0Error, bus.c1Error}, 0);
        check("rst_rdata", {bus.c0ReadData, bus.c1ReadData}, 0);
        check("rst_addr", {bus.memoryXCoord, bus.memoryYCoord, bus.memoryWriteData}, 0);
        reset = 1'b0;

        // Single write from client 0
        bus.c0Request = 1'b1; bus.c0Write = 1'b1; bus.c0XCoord = 9'd5;
        bus.c0YCoord = 8'd7; bus.c0WriteData = 8'hA5;
        tick();
        check("wr_req", {bus.memoryWriteRequest, bus.memoryReadRequest}, 2'b10);
        check("wr_addr", {bus.memoryYCoord, bus.memoryXCoord}, {8'd7, 9'd5});
        check("wr_data", bus.memoryWriteData, 8'hA5);
        check("wr_grant", bus.grantOwner, 0);
        pushExp(1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wr_hold", bus.memoryWriteRequest, 1);
        end
        bus.memoryReadData = 8'hEE;
        bus.memoryWriteComplete = 1'b1;
        tick();
        bus.memoryWriteComplete = 1'b0;
        bus.c0Request = 1'b0;
        popCheck("wr");
        tick();
        check("wr_doneFall", bus.c0Done, 0);
        check("wr_rdataUntouched", bus.c0ReadData, 0);

        // Single read from client 1
        bus.c1Request = 1'b1; bus.c1Write = 1'b0; bus.c1XCoord = 9'd319; bus.c1YCoord = 8'd239;
        tick();
        check("rd_req", {bus.memoryWriteRequest, bus.memoryReadRequest}, 2'b01);
        check("rd_addr", {bus.memoryYCoord, bus.memoryXCoord}, {8'd239, 9'd319});
        check("rd_grant", bus.grantOwner, 1);
        pushExp(1'b1, 1'b0, 1'b1, 8'h3C);
        tick();
        bus.c1Request = 1'b0;
        finishTxn("rd", 1'b0, 8'h3C);
        check("rd_hold", bus.c1ReadData, 8'h3C);

        // Contention from reset: grants alternate 0,1,0,1 with both requests held
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.c0Request = 1'b1; bus.c0Write = 1'b1; bus.c0XCoord = 9'd10; bus.c0WriteData = 8'h11;
        bus.c1Request = 1'b1; bus.c1Write = 1'b0; bus.c1XCoord = 9'd20;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("cont_grant", bus.grantOwner, i % 2);
            check("cont_req", {bus.memoryWriteRequest, bus.memoryReadRequest},
                  (i % 2 == 0) ? 2'b10 : 2'b01);
            check("cont_x", bus.memoryXCoord, (i % 2 == 0) ? 9'd10 : 9'd20);
            pushExp(1'(i % 2), 1'b0, 1'(i % 2), 8'h40 + 8'(i));
            tick();
            if (i == 3) begin
                bus.c0Request = 1'b0;
                bus.c1Request = 1'b0;
            end
            finishTxn("cont", (i % 2 == 0), 8'h40 + 8'(i));
        end

        // Wrong completion type is ignored
        bus.c0Request = 1'b1; bus.c0Write = 1'b0; bus.c0XCoord = 9'd1;
        tick();
        check("wrong_req", bus.memoryReadRequest, 1);
        pushExp(1'b0, 1'b0, 1'b1, 8'h77);
        bus.memoryWriteComplete = 1'b1;
        tick();
        bus.memoryWriteComplete = 1'b0;
        check("wrong_ignored", bus.memoryReadRequest, 1);
        check("wrong_noDone", bus.c0Done, 0);
        tick();
        check("wrong_hold", bus.memoryReadRequest, 1);
        bus.c0Request = 1'b0;
        finishTxn("wrong", 1'b0, 8'h77);
        check("wrong_rdata", bus.c0ReadData, 8'h77);

        // Watchdog: request high exactly 15 cycles, then aborted read returns 0
        bus.c0Request = 1'b1; bus.c0Write = 1'b0;
        tick();
        pushExp(1'b0, 1'b1, 1'b1, 8'd0);
        check("to_req1", bus.memoryReadRequest, 1);
        for (int i = 2; i <= 15; i++) begin
            tick();
            check("to_reqHigh", bus.memoryReadRequest, 1);
        end
        bus.c0Request = 1'b0;
        tick();
        popCheck("to");
        tick();
        check("to_doneFall", {bus.c0Done, bus.c0Error}, 0);

        // Normal transaction after a timeout
        bus.c0Request = 1'b1; bus.c0Write = 1'b1; bus.c0XCoord = 9'd100; bus.c0WriteData = 8'h5A;
        tick();
        check("post_req", bus.memoryWriteRequest, 1);
        check("post_data", bus.memoryWriteData, 8'h5A);
        pushExp(1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        bus.c0Request = 1'b0;
        finishTxn("post", 1'b1, 8'd0);

        // Reset mid-BUSY clears outputs asynchronously; c0 then wins the first tie
        bus.c0Request = 1'b1; bus.c0Write = 1'b1;
        tick();
        check("rb_req", bus.memoryWriteRequest, 1);
        check("rb_grant", bus.grantOwner, 0);
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("rb_asyncReq", {bus.memoryReadRequest, bus.memoryWriteRequest}, 0);
        check("rb_asyncBusy", bus.busy, 0);
        check("rb_asyncDone", {bus.c0Done, bus.c1Done}, 0);
        tick();
        reset = 1'b0;
        bus.c1Request = 1'b1; bus.c1Write = 1'b0;
        tick();
        check("rb_tieGrant", bus.grantOwner, 0);
        check("rb_tieReq", bus.memoryWriteRequest, 1);
        pushExp(1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        bus.c0Request = 1'b0;
        bus.c1Request = 1'b0;
        finishTxn("rb", 1'b1, 8'd0);

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
